// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output Ovf.
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
   output logic             Ovf,
`endif
   output logic             Bout
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LastCount = CW'(WIDTH - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StShift = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]       state_q;
   logic [CW-1:0]    count_q;
   logic             borrow_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] d_sh_q;

   logic             d;
   logic             borrow_d;
   logic [WIDTH-1:0] d_sh_d;

`ifdef SERIAL_SUB_OVERFLOW_EN
   // Operand sign bits are shifted out of a_sh/b_sh, so keep them aside.
   logic a_msb_q;
   logic b_msb_q;
`endif

   // Single full-subtractor cell operating on the current LSBs.
   always_comb begin
      d        = a_sh_q[0] ^ b_sh_q[0] ^ borrow_q;
      borrow_d = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & borrow_q);
      d_sh_d   = {d, d_sh_q[WIDTH-1:1]};
   end

   always_comb begin
      busy = (state_q == StShift);
      done = (state_q == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         count_q  <= '0;
         borrow_q <= 1'b0;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         d_sh_q   <= '0;
         Diff     <= '0;
         Bout     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         Ovf      <= 1'b0;
`endif
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_sh_q   <= A;
                  b_sh_q   <= B;
                  borrow_q <= Bin;
                  count_q  <= '0;
                  state_q  <= StShift;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  a_msb_q  <= A[WIDTH-1];
                  b_msb_q  <= B[WIDTH-1];
`endif
               end else begin
                  state_q <= StIdle;
               end
            end
            StShift: begin
               borrow_q <= borrow_d;
               d_sh_q   <= d_sh_d;
               a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
               b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
               count_q  <= count_q + CW'(1);
               if (count_q == LastCount) begin
                  Diff    <= d_sh_d;
                  Bout    <= borrow_d;
                  state_q <= StDone;
`ifdef SERIAL_SUB_OVERFLOW_EN
                  // The cell's current output d is the result MSB.
                  Ovf     <= (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=2 instances).
// Checks Ovf as well when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst8, start8, bin8;
   logic [7:0] a8, b8;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;
   logic       rst2, start2, bin2;
   logic [1:0] a2, b2;
   logic       busy2, done2, bout2;
   logic [1:0] diff2;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic       ovf8, ovf2;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int done2_cnt = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst   (rst8),
      .start (start8),
      .A     (a8),
      .B     (b8),
      .Bin   (bin8),
      .busy  (busy8),
      .done  (done8),
      .Diff  (diff8),
`ifdef SERIAL_SUB_OVERFLOW_EN
      .Ovf   (ovf8),
`endif
      .Bout  (bout8)
   );

   serial_subtractor #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst2),
      .start (start2),
      .A     (a2),
      .B     (b2),
      .Bin   (bin2),
      .busy  (busy2),
      .done  (done2),
      .Diff  (diff2),
`ifdef SERIAL_SUB_OVERFLOW_EN
      .Ovf   (ovf2),
`endif
      .Bout  (bout2)
   );

   always @(posedge clk) if (done2) done2_cnt <= done2_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on the unsigned and signed operand values.
   function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic bi);
      int r;
      int sr;
      logic [7:0] dv;
      r  = int'(a) - int'(b) - int'(bi);
      sr = int'($signed(a)) - int'($signed(b)) - int'(bi);
      dv = r[7:0];
      return {(sr > 127 || sr < -128), (r < 0), dv};
   endfunction

   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input bit inject);
      int cyc;
      int busy_cnt;
      bit stable;
      logic [7:0] prev_diff;
      logic       prev_bout;
      logic [9:0] exp;
      exp       = model8(a, b, bi);
      prev_diff = diff8;
      prev_bout = bout8;
      a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      busy_cnt = busy8 ? 1 : 0;
      stable = 1'b1;
      cyc = 0;
      while (!done8 && cyc < 20) begin
         if (inject && cyc == 2) begin
            start8 = 1'b1;
            a8 = 8'hFF;
         end else begin
            start8 = 1'b0;
         end
         tick();
         cyc++;
         if (busy8) busy_cnt++;
         if (!done8 && (diff8 !== prev_diff || bout8 !== prev_bout)) stable = 1'b0;
      end
      start8 = 1'b0;
      check("latency", cyc, 8);
      check("busy_cycles", busy_cnt, 8);
      check("hold_during_shift", stable, 1);
      check("diff", diff8, exp[7:0]);
      check("bout", bout8, exp[8]);
`ifdef SERIAL_SUB_OVERFLOW_EN
      check("ovf", ovf8, exp[9]);
`endif
      tick();
      check("done_one_cycle", {busy8, done8}, 2'b00);
   endtask

   task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic bi);
      int cyc;
      int r;
      logic [1:0] ed;
      r  = int'(a) - int'(b) - int'(bi);
      ed = r[1:0];
      a2 = a; b2 = b; bin2 = bi; start2 = 1'b1;
      tick();
      start2 = 1'b0;
      cyc = 0;
      while (!done2 && cyc < 10) begin
         tick();
         cyc++;
      end
      check("w2_result", {cyc[3:0], bout2, diff2}, {4'd2, (r < 0), ed});
      tick();
   endtask

   initial begin
      logic [7:0] qa[4];
      logic [7:0] qb[4];
      logic       qi[4];
      logic [9:0] exp;
      int cyc;
      int dcount;

      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
      rst2 = 1'b1; start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
      tick(); tick();
      rst8 = 1'b0; rst2 = 1'b0;
      check("reset_state", {busy8, done8, bout8, diff8}, 11'd0);
      tick();
      check("idle_no_start", {busy8, done8}, 2'b00);

      run8(8'h05, 8'h03, 1'b0, 1'b0);
      run8(8'h03, 8'h05, 1'b0, 1'b0);
      run8(8'h00, 8'h00, 1'b1, 1'b0);
      run8(8'h80, 8'h01, 1'b0, 1'b0);
      run8(8'h10, 8'h01, 1'b0, 1'b0);
      run8(8'h12, 8'h34, 1'b0, 1'b1);
      for (int i = 0; i < 30; i++)
         run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

      // Back-to-back: start stays high, next operands presented during each SHIFT.
      for (int i = 0; i < 4; i++) begin
         qa[i] = 8'($urandom); qb[i] = 8'($urandom); qi[i] = 1'($urandom);
      end
      a8 = qa[0]; b8 = qb[0]; bin8 = qi[0]; start8 = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i < 3) begin
            a8 = qa[i+1]; b8 = qb[i+1]; bin8 = qi[i+1];
         end else begin
            start8 = 1'b0;
         end
         cyc = 0;
         while (!done8 && cyc < 20) begin
            tick();
            cyc++;
         end
         exp = model8(qa[i], qb[i], qi[i]);
         check("b2b_latency", cyc, 8);
         check("b2b_result", {bout8, diff8}, exp[8:0]);
         tick();
         check("b2b_no_gap", busy8, (i < 3) ? 1 : 0);
      end
      tick();

      // Reset during the 4th SHIFT cycle aborts and clears the result.
      run8(8'h03, 8'h05, 1'b0, 1'b0);
      a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); tick(); tick();
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      check("abort_state", {busy8, done8, bout8, diff8}, 11'd0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done8 || busy8) dcount++;
      end
      check("abort_no_done", dcount, 0);

      // Reset wins over start on the same edge.
      rst8 = 1'b1; start8 = 1'b1;
      tick();
      rst8 = 1'b0; start8 = 1'b0;
      check("rst_over_start", busy8, 0);

      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int bi = 0; bi < 2; bi++)
               run2(2'(a), 2'(b), 1'(bi));
      check("w2_done_count", done2_cnt, 32);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
